// File: rtl/rmii_tx_mac.sv
// RMII transmit MAC: fetches a frame body from packet RAM and sends preamble, SFD,
// body, zero pad and CRC-32 FCS as dibits, followed by the inter-frame gap.
module rmii_tx_mac #(
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_vld,
  input  logic [10:0] tx_count,
  output logic [10:0] tx_addr,
  output logic        tx_adv,
  input  logic [7:0]  tx_data,
  output logic        tx_busy,
  output logic        tx_last,
  output logic        eth_clk,
  output logic [1:0]  eth_txd,
  output logic        eth_tx_en
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  localparam logic [10:0] IFG_L = 11'(IFG_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

  state_t      r_state;
  logic        r_phase;
  logic [1:0]  r_dib;
  logic [10:0] r_idx;
  logic [10:0] r_len;
  logic [7:0]  r_sr;
  logic [7:0]  r_nxt;
  logic [31:0] r_crc;
  logic        r_adv;
  logic        r_cap;
  logic [10:0] r_addr;
  logic        r_busy;
  logic        r_last;
  logic        r_en;
  logic [1:0]  r_txd;

  logic        w_tick;
  logic [10:0] w_len_clip;
  logic [10:0] w_idx_inc;
  logic        w_last_data;
  logic        w_pad;
  logic        w_pad_end;
  logic        w_sending;
  logic        w_fetch;
  logic [7:0]  w_fcs_nxt;
  logic [31:0] w_crc_d;
  logic [31:0] w_crc_z;

  // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction

  // A dibit boundary is every edge where phase falls, so txd is stable at eth_clk rise.
  assign w_tick      = r_phase;
  assign w_len_clip  = (tx_count > MAX_L) ? MAX_L : tx_count;
  assign w_idx_inc   = r_idx + 11'd1;
  assign w_last_data = (w_idx_inc == r_len);
  assign w_pad       = (r_len < MIN_L);
  assign w_pad_end   = (r_len + r_idx == MIN_L - 11'd1);
  assign w_sending   = (r_state != S_IDLE) && (r_state != S_IFG);
  assign w_fetch     = ((r_state == S_PRE) && (r_idx == 11'd7)) ||
                       ((r_state == S_DATA) && !w_last_data);
  assign w_fcs_nxt   = ~r_crc[{r_idx[1:0] + 2'd1, 3'b000} +: 8];
  assign w_crc_d     = crc_byte(r_crc, r_nxt);
  assign w_crc_z     = crc_byte(r_crc, 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
      r_dib   <= 2'd0;
      r_idx   <= 11'd0;
      r_len   <= 11'd0;
      r_sr    <= 8'h00;
      r_crc   <= 32'hFFFFFFFF;
      r_adv   <= 1'b0;
      r_cap   <= 1'b0;
      r_addr  <= 11'd0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
      r_en    <= 1'b0;
      r_txd   <= 2'b00;
    end else begin
      r_phase <= ~r_phase;
      r_adv   <= 1'b0;
      r_cap   <= r_adv;
      r_last  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (tx_vld && (tx_count != 11'd0)) begin
          r_len   <= w_len_clip;
          r_idx   <= 11'd0;
          r_dib   <= 2'd0;
          r_sr    <= 8'h55;
          r_crc   <= 32'hFFFFFFFF;
          r_busy  <= 1'b1;
          r_state <= S_PRE;
        end
      end else if (w_tick) begin
        r_dib <= r_dib + 2'd1;
        r_en  <= w_sending;
        r_txd <= w_sending ? r_sr[{r_dib, 1'b0} +: 2] : 2'b00;
        if ((r_state == S_IFG) && (r_idx == 11'd0) && (r_dib == 2'd0))
          r_last <= 1'b1;
        // Next RAM byte is requested one full byte time ahead of its first dibit.
        if ((r_dib == 2'd0) && w_fetch) begin
          r_adv  <= 1'b1;
          r_addr <= (r_state == S_PRE) ? 11'd0 : w_idx_inc;
        end
        if (r_dib == 2'd3) begin
          r_idx <= w_idx_inc;
          case (r_state)
            S_PRE: begin
              if (r_idx == 11'd7) begin
                r_state <= S_DATA;
                r_idx   <= 11'd0;
                r_sr    <= r_nxt;
                r_crc   <= w_crc_d;
              end else begin
                r_sr <= (r_idx == 11'd6) ? 8'hD5 : 8'h55;
              end
            end
            S_DATA: begin
              if (w_last_data) begin
                r_idx <= 11'd0;
                if (w_pad) begin
                  r_state <= S_PAD;
                  r_sr    <= 8'h00;
                  r_crc   <= w_crc_z;
                end else begin
                  r_state <= S_FCS;
                  r_sr    <= ~r_crc[7:0];
                end
              end else begin
                r_sr  <= r_nxt;
                r_crc <= w_crc_d;
              end
            end
            S_PAD: begin
              if (w_pad_end) begin
                r_state <= S_FCS;
                r_idx   <= 11'd0;
                r_sr    <= ~r_crc[7:0];
              end else begin
                r_sr  <= 8'h00;
                r_crc <= w_crc_z;
              end
            end
            S_FCS: begin
              if (r_idx == 11'd3) begin
                r_state <= S_IFG;
                r_idx   <= 11'd0;
                r_sr    <= 8'h00;
              end else begin
                r_sr <= w_fcs_nxt;
              end
            end
            S_IFG: begin
              if (r_idx == IFG_L) begin
                r_state <= S_IDLE;
                r_idx   <= 11'd0;
                r_busy  <= 1'b0;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_cap) r_nxt <= tx_data;
  end

  assign tx_addr   = r_addr;
  assign tx_adv    = r_adv;
  assign tx_busy   = r_busy;
  assign tx_last   = r_last;
  assign eth_clk   = r_phase;
  assign eth_txd   = r_txd;
  assign eth_tx_en = r_en;

endmodule

// File: tb/tb_rmii_tx_mac.sv
// Bench for rmii_tx_mac: RAM model, wire-byte/fetch/frame-length scoreboards.
module tb_rmii_tx_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_vld;
  logic [10:0] tx_count;
  logic [10:0] tx_addr;
  logic        tx_adv;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_busy;
  logic        tx_last;
  logic        eth_clk;
  logic [1:0]  eth_txd;
  logic        eth_tx_en;

  rmii_tx_mac dut (
    .clk       (clk),
    .reset     (reset),
    .tx_vld    (tx_vld),
    .tx_count  (tx_count),
    .tx_addr   (tx_addr),
    .tx_adv    (tx_adv),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_last   (tx_last),
    .eth_clk   (eth_clk),
    .eth_txd   (eth_txd),
    .eth_tx_en (eth_tx_en)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  always @(posedge clk) if (tx_adv) tx_data <= mem[tx_addr];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_adv  = 0;
  int en_cnt = 0;
  int m_dcnt = 0;
  logic [7:0]  m_byte = 8'h00;
  logic [8:0]  q_exp  [$];
  logic [11:0] q_addr [$];
  int          q_len  [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ b[k];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic push_frame(input int cnt);
    int L;
    int N;
    logic [31:0] crc;
    logic [7:0] b;
    L = (cnt > 1514) ? 1514 : cnt;
    N = (L < 60) ? 60 : L;
    for (int i = 0; i < 7; i++) q_exp.push_back(9'h055);
    q_exp.push_back(9'h0D5);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < N; i++) begin
      b = (i < L) ? mem[i] : 8'h00;
      q_exp.push_back({1'b0, b});
      crc = crc_upd(crc, b);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) q_exp.push_back({1'b0, crc[8*i +: 8]});
    for (int i = 0; i < L; i++) q_addr.push_back(12'(i));
    q_len.push_back((12 + N) * 8);
  endtask

  // Wire monitor: one dibit per eth_clk-high cycle, bytes assembled LSB first.
  always @(negedge clk) begin
    logic [8:0]  e9;
    logic [11:0] ea;
    int          el;
    if (reset) begin
      m_dcnt = 0;
      en_cnt = 0;
    end else begin
      if (eth_tx_en) en_cnt++;
      if (eth_tx_en && eth_clk) begin
        m_byte = {eth_txd, m_byte[7:2]};
        m_dcnt++;
        if (m_dcnt == 4) begin
          m_dcnt = 0;
          if (q_exp.size() != 0) e9 = q_exp.pop_front();
          else e9 = 9'h100;
          chk("wire_byte", {23'd0, 1'b0, m_byte}, {23'd0, e9});
        end
      end
      if (tx_last) begin
        chk("last_en_low", {31'd0, eth_tx_en}, 32'd0);
        if (q_len.size() != 0) el = q_len.pop_front();
        else el = -1;
        chk("en_high_clk", en_cnt, el);
        en_cnt = 0;
        m_dcnt = 0;
      end
      if (tx_adv) begin
        n_adv++;
        if (q_addr.size() != 0) ea = q_addr.pop_front();
        else ea = 12'h800;
        chk("fetch_addr", {20'd0, 1'b0, tx_addr}, {20'd0, ea});
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (tx_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_done", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic send_frame(input int cnt);
    int L;
    L = (cnt > 1514) ? 1514 : cnt;
    push_frame(cnt);
    n_adv = 0;
    @(negedge clk);
    tx_count = 11'(cnt);
    tx_vld   = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    chk("busy_latency", {31'd0, tx_busy}, 32'd1);
    repeat (2) @(negedge clk);
    chk("first_dibit", {31'd0, eth_tx_en}, 32'd1);
    wait_idle(20000);
    chk("bytes_left", q_exp.size(), 0);
    chk("fetch_left", q_addr.size(), 0);
    chk("adv_count", n_adv, L);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p;
    logic pn;
    int   k;
    int   cyc_last;
    int   g_ok;
    reset    = 1'b1;
    tx_vld   = 1'b0;
    tx_count = 11'd0;
    fill_rand();
    repeat (3) @(negedge clk);
    chk("rst_busy",    {31'd0, tx_busy},   32'd0);
    chk("rst_adv",     {31'd0, tx_adv},    32'd0);
    chk("rst_last",    {31'd0, tx_last},   32'd0);
    chk("rst_addr",    {21'd0, tx_addr},   32'd0);
    chk("rst_txd",     {30'd0, eth_txd},   32'd0);
    chk("rst_en",      {31'd0, eth_tx_en}, 32'd0);
    chk("rst_eth_clk", {31'd0, eth_clk},   32'd0);
    reset = 1'b0;
    @(negedge clk);
    p = eth_clk;
    @(negedge clk);
    pn = ~p;
    chk("eth_clk_toggle", {31'd0, eth_clk}, {31'd0, pn});

    // Zero-length request is ignored.
    n_adv    = 0;
    tx_count = 11'd0;
    tx_vld   = 1'b1;
    repeat (3) @(negedge clk);
    tx_vld = 1'b0;
    chk("zero_cnt_idle", {31'd0, tx_busy}, 32'd0);
    chk("zero_cnt_adv", n_adv, 0);

    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4; mem[4] = 8'hE5;
    send_frame(5);
    fill_rand();
    send_frame(42);
    fill_rand();
    mem[0] = 8'h00; mem[1] = 8'h10; mem[2] = 8'hA4; mem[3] = 8'h7B; mem[4] = 8'hEA; mem[5] = 8'h80;
    send_frame(60);
    fill_rand();
    send_frame(64);
    fill_rand();
    send_frame(2000);

    // Back-to-back with tx_vld held high, then stray pulses while busy.
    fill_rand();
    push_frame(20);
    push_frame(20);
    n_adv = 0;
    @(negedge clk);
    tx_count = 11'd20;
    tx_vld   = 1'b1;
    k = 0;
    while (!tx_last && k < 2000) begin @(negedge clk); k++; end
    chk("b2b_last1", {31'd0, tx_last}, 32'd1);
    cyc_last = cyc;
    k = 0;
    while (tx_busy && k < 300) begin @(negedge clk); k++; end
    chk("b2b_idle", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    chk("b2b_restart", {31'd0, tx_busy}, 32'd1);
    tx_vld = 1'b0;
    k = 0;
    while (!eth_tx_en && k < 20) begin @(negedge clk); k++; end
    g_ok = ((cyc - cyc_last) >= 96) ? 1 : 0;
    chk("ifg_gap", g_ok, 1);
    repeat (30) @(negedge clk);
    tx_count = 11'd7;
    tx_vld   = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    wait_idle(2000);
    repeat (12) @(negedge clk);
    chk("no_extra_frame", {31'd0, tx_busy}, 32'd0);
    chk("b2b_bytes_left", q_exp.size(), 0);
    chk("b2b_adv_count", n_adv, 40);

    // Reset in the middle of the body, then a clean frame.
    fill_rand();
    push_frame(40);
    n_adv = 0;
    @(negedge clk);
    tx_count = 11'd40;
    tx_vld   = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    k = 0;
    while (!(tx_adv && tx_addr == 11'd20) && k < 1000) begin @(negedge clk); k++; end
    chk("reach_byte20", {21'd0, tx_addr}, 32'd20);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_en",   {31'd0, eth_tx_en}, 32'd0);
    chk("mid_rst_busy", {31'd0, tx_busy},   32'd0);
    chk("mid_rst_adv",  {31'd0, tx_adv},    32'd0);
    chk("mid_rst_txd",  {30'd0, eth_txd},   32'd0);
    chk("mid_rst_addr", {21'd0, tx_addr},   32'd0);
    q_exp.delete();
    q_addr.delete();
    q_len.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send_frame(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
